// File: rtl/transmission_pkg.sv
// Shared types and default widths for the FIFO transmission sequence checker.
package transmission_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int DATA_W_DEF   = 32;
    localparam int CNT_W_DEF    = 32;
    localparam int LOCK_LEN_DEF = 4;

    // Bits needed to hold a run length of 0..len
    function automatic int run_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/transmission_check_sat_counter.sv
// Saturating accumulator: adds inc_amt_i when inc_en_i, pins at all-ones, clear wins.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clear_i,
    input  logic         inc_en_i,
    input  logic [W-1:0] inc_amt_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + {1'b0, inc_amt_i};
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_en_i)
            cnt_d = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/transmission_check.sv
// Receive-side checker for the incrementing word stream: hunts for lock, flags
// out-of-order words while locked. Define TRANSMISSION_CHECK_LOST_EN for lost_cnt_out.
module transmission_check
    import transmission_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_LEN = LOCK_LEN_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              clear_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              locked_out,
    output logic              error_out,
    output logic [CNT_W-1:0]  word_cnt_out,
    output logic [CNT_W-1:0]  err_cnt_out
`ifdef TRANSMISSION_CHECK_LOST_EN
    ,
    output logic [CNT_W-1:0]  lost_cnt_out
`endif
);

    localparam int               RUN_W    = run_width(LOCK_LEN);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);

    state_e            state_q;
    logic [DATA_W-1:0] expected_q;
    logic [RUN_W-1:0]  run_q;
    logic [RUN_W-1:0]  run_d;
    logic              error_q;
    logic              match;
    logic              accept;
    logic              locked_miss;

    assign match       = (data_in == expected_q);
    assign accept      = valid_in && !clear_in;
    assign locked_miss = accept && (state_q == LOCKED) && !match;

    // Run length while hunting; a mismatching word starts a fresh run of one
    always_comb begin
        run_d = RUN_W'(1);
        if (match)
            run_d = (run_q >= LOCK_RUN) ? LOCK_RUN : run_q + RUN_W'(1);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= HUNT;
            expected_q <= '0;
            run_q      <= '0;
            error_q    <= 1'b0;
        end else if (clear_in) begin
            state_q    <= HUNT;
            expected_q <= '0;
            run_q      <= '0;
            error_q    <= 1'b0;
        end else if (valid_in) begin
            expected_q <= data_in + DATA_W'(1);
            error_q    <= 1'b0;
            case (state_q)
                HUNT: begin
                    run_q <= run_d;
                    if (run_d == LOCK_RUN)
                        state_q <= LOCKED;
                end
                LOCKED: begin
                    if (!match) begin
                        error_q <= 1'b1;
                        run_q   <= RUN_W'(1);
                        state_q <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end else begin
            error_q <= 1'b0;
        end
    end

    assign locked_out = (state_q == LOCKED);
    assign error_out  = error_q;

    sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk_i     (clk_in),
        .rst_n_i   (rst_n_in),
        .clear_i   (clear_in),
        .inc_en_i  (accept),
        .inc_amt_i (CNT_W'(1)),
        .cnt_o     (word_cnt_out)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_i     (clk_in),
        .rst_n_i   (rst_n_in),
        .clear_i   (clear_in),
        .inc_en_i  (locked_miss),
        .inc_amt_i (CNT_W'(1)),
        .cnt_o     (err_cnt_out)
    );

`ifdef TRANSMISSION_CHECK_LOST_EN
    logic [DATA_W-1:0] gap;
    logic [CNT_W-1:0]  gap_cnt;

    // Words skipped between the expected value and what actually arrived
    assign gap     = data_in - expected_q;
    assign gap_cnt = CNT_W'(gap);

    sat_counter #(.W(CNT_W)) u_lost_cnt (
        .clk_i     (clk_in),
        .rst_n_i   (rst_n_in),
        .clear_i   (clear_in),
        .inc_en_i  (locked_miss),
        .inc_amt_i (gap_cnt),
        .cnt_o     (lost_cnt_out)
    );
`endif

endmodule

// File: tb/tb_transmission_check.sv
// Bench for transmission_check: vector table through a scoreboard queue, plus
// saturation (CNT_W=4 instance) and asynchronous reset sequences.
module tb_transmission_check;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, valid;
    logic [31:0] data;
    logic        locked, error;
    logic [31:0] word_cnt, err_cnt, lost_cnt;

    logic        s_clear, s_valid;
    logic [31:0] s_data;
    logic        s_locked, s_error;
    logic [3:0]  s_word, s_err, s_lost;

    transmission_check dut (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .data_in(data), .valid_in(valid),
        .locked_out(locked), .error_out(error), .word_cnt_out(word_cnt), .err_cnt_out(err_cnt)
`ifdef TRANSMISSION_CHECK_LOST_EN
        , .lost_cnt_out(lost_cnt)
`endif
    );

    transmission_check #(.CNT_W(4)) dut_s (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(s_clear), .data_in(s_data), .valid_in(s_valid),
        .locked_out(s_locked), .error_out(s_error), .word_cnt_out(s_word), .err_cnt_out(s_err)
`ifdef TRANSMISSION_CHECK_LOST_EN
        , .lost_cnt_out(s_lost)
`endif
    );

`ifndef TRANSMISSION_CHECK_LOST_EN
    assign lost_cnt = '0;
    assign s_lost   = '0;
`endif

    typedef struct {
        logic        clr;
        logic        vld;
        logic [31:0] d;
        logic        lk;
        logic        er;
        logic [31:0] wc;
        logic [31:0] ec;
        logic [31:0] lc;
    } vec_t;

    vec_t tbl[30];
    vec_t sb[$];
    int   s_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic v, input logic [31:0] d,
                                input logic lk, input logic er, input int wc, input int ec, input int lc);
        vec_t r;
        r.clr = c; r.vld = v; r.d = d; r.lk = lk; r.er = er;
        r.wc = 32'(wc); r.ec = 32'(ec); r.lc = 32'(lc);
        return r;
    endfunction

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        clear = v.clr; valid = v.vld; data = v.d;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " locked"}, 64'(locked), 64'(e.lk));
        chk({tag, " error"}, 64'(error), 64'(e.er));
        chk({tag, " word_cnt"}, 64'(word_cnt), 64'(e.wc));
        chk({tag, " err_cnt"}, 64'(err_cnt), 64'(e.ec));
`ifdef TRANSMISSION_CHECK_LOST_EN
        chk({tag, " lost_cnt"}, 64'(lost_cnt), 64'(e.lc));
`endif
        clear = 1'b0; valid = 1'b0;
    endtask

    function automatic int sat15(input int a);
        return (a > 15) ? 15 : a;
    endfunction

    int s_w = 0, s_e = 0;

    task automatic s_step(input logic [31:0] d, input logic is_err);
        int ew, ee;
        @(negedge clk);
        s_valid = 1'b1; s_data = d;
        s_w = sat15(s_w + 1);
        if (is_err) s_e = sat15(s_e + 1);
        s_q.push_back(s_w);
        s_q.push_back(s_e);
        @(posedge clk);
        #1;
        ew = s_q.pop_front();
        ee = s_q.pop_front();
        chk($sformatf("sat word_cnt d=%0d", d), 64'(s_word), 64'(ew));
        chk($sformatf("sat err_cnt d=%0d", d), 64'(s_err), 64'(ee));
        chk($sformatf("sat error d=%0d", d), 64'(s_error), 64'(is_err));
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           clr vld data          lk er wc ec lost
        tbl[0]  = mk(0, 1, 32'd0,          0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 1, 32'd1,          0, 0, 2, 0, 0);
        tbl[2]  = mk(0, 1, 32'd2,          0, 0, 3, 0, 0);
        tbl[3]  = mk(0, 1, 32'd3,          1, 0, 4, 0, 0);
        tbl[4]  = mk(0, 0, 32'd99,         1, 0, 4, 0, 0);
        tbl[5]  = mk(0, 1, 32'd4,          1, 0, 5, 0, 0);
        tbl[6]  = mk(0, 1, 32'd5,          1, 0, 6, 0, 0);
        tbl[7]  = mk(0, 1, 32'd6,          1, 0, 7, 0, 0);
        tbl[8]  = mk(0, 1, 32'd7,          1, 0, 8, 0, 0);
        tbl[9]  = mk(0, 1, 32'd8,          1, 0, 9, 0, 0);
        tbl[10] = mk(0, 1, 32'd9,          1, 0, 10, 0, 0);
        tbl[11] = mk(0, 1, 32'd13,         0, 1, 11, 1, 3);
        tbl[12] = mk(0, 1, 32'd14,         0, 0, 12, 1, 3);
        tbl[13] = mk(0, 1, 32'd15,         0, 0, 13, 1, 3);
        tbl[14] = mk(0, 1, 32'd16,         1, 0, 14, 1, 3);
        tbl[15] = mk(0, 1, 32'd50,         0, 1, 15, 2, 36);
        tbl[16] = mk(0, 1, 32'd7,          0, 0, 16, 2, 36);
        tbl[17] = mk(0, 1, 32'hFFFFFFFB,   0, 0, 17, 2, 36);
        tbl[18] = mk(0, 1, 32'hFFFFFFFC,   0, 0, 18, 2, 36);
        tbl[19] = mk(0, 1, 32'hFFFFFFFD,   0, 0, 19, 2, 36);
        tbl[20] = mk(0, 1, 32'hFFFFFFFE,   1, 0, 20, 2, 36);
        tbl[21] = mk(0, 1, 32'hFFFFFFFF,   1, 0, 21, 2, 36);
        tbl[22] = mk(0, 1, 32'h00000000,   1, 0, 22, 2, 36);
        tbl[23] = mk(0, 1, 32'h00000001,   1, 0, 23, 2, 36);
        tbl[24] = mk(1, 1, 32'd5,          0, 0, 0, 0, 0);
        tbl[25] = mk(0, 1, 32'd0,          0, 0, 1, 0, 0);
        tbl[26] = mk(0, 1, 32'd1,          0, 0, 2, 0, 0);
        tbl[27] = mk(0, 1, 32'd2,          0, 0, 3, 0, 0);
        tbl[28] = mk(0, 1, 32'd3,          1, 0, 4, 0, 0);
        tbl[29] = mk(1, 0, 32'd0,          0, 0, 0, 0, 0);

        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; data = '0;
        s_clear = 1'b0; s_valid = 1'b0; s_data = '0;
        #3;
        chk("reset locked", 64'(locked), 64'(0));
        chk("reset error", 64'(error), 64'(0));
        chk("reset word_cnt", 64'(word_cnt), 64'(0));
        chk("reset err_cnt", 64'(err_cnt), 64'(0));
        chk("reset lost_cnt", 64'(lost_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Each round: re-lock on four in-sequence words, then one locked mismatch
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 4; k++)
                s_step(32'(r * 100 + k), 1'b0);
            s_step(32'(r * 100 + 50), 1'b1);
        end
        chk("sat word_cnt final", 64'(s_word), 64'(15));
        chk("sat err_cnt final", 64'(s_err), 64'(15));
`ifdef TRANSMISSION_CHECK_LOST_EN
        chk("sat lost_cnt final", 64'(s_lost), 64'(15));
`endif

        step(mk(0, 1, 32'd0, 0, 0, 1, 0, 0), "pre0");
        step(mk(0, 1, 32'd1, 0, 0, 2, 0, 0), "pre1");
        step(mk(0, 1, 32'd2, 0, 0, 3, 0, 0), "pre2");
        step(mk(0, 1, 32'd3, 1, 0, 4, 0, 0), "pre3");
        @(negedge clk);
        valid = 1'b1; data = 32'd4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async locked", 64'(locked), 64'(0));
        chk("async error", 64'(error), 64'(0));
        chk("async word_cnt", 64'(word_cnt), 64'(0));
        chk("async err_cnt", 64'(err_cnt), 64'(0));
        chk("async sat word_cnt", 64'(s_word), 64'(0));
        chk("async sat err_cnt", 64'(s_err), 64'(0));
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        step(mk(0, 1, 32'd0, 0, 0, 1, 0, 0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/transmission_check.md
# transmission_check

Receive-side sequence checker for the FIFO transmission test path. It sits at the output of the master FIFO link and consumes the 32-bit incrementing word stream produced by the transmission test generator, which emits 0, 1, 2, … and wraps from 0xFFFFFFFF to 0. The checker locks onto the sequence and flags every out-of-order word. It also keeps saturating statistics that software or a logic analyser reads to qualify the link.

## Interface
Parameters:
- DATA_W, 32, width of the checked word; the sequence wraps modulo 2^DATA_W.
- CNT_W, 32, width of every statistics counter.
- LOCK_LEN, 4, number of consecutive in-sequence words required to declare lock (≥1).

Ports:
- clk_in  in  1  single clock; all logic is on its rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- clear_in  in  1  synchronous clear of counters and state; takes priority over valid_in.
- data_in  in  DATA_W  received word.
- valid_in  in  1  data_in is valid this cycle; there is no backpressure, so the checker accepts every word.
- locked_out  out  1  the checker is locked to the sequence.
- error_out  out  1  one-cycle pulse on a mismatch detected while locked.
- word_cnt_out  out  CNT_W  total valid words received.
- err_cnt_out  out  CNT_W  mismatches detected while locked.
- lost_cnt_out  out  CNT_W  estimated words skipped; present only with the configuration macro.

## Operation
- States: HUNT and LOCKED. Reset and clear_in both enter HUNT.
- Registers: expected (DATA_W) and run (counts up to LOCK_LEN).
- HUNT, valid word:
  - if data_in == expected, run increments; otherwise run is set to 1.
  - expected is always loaded with data_in+1 (mod 2^DATA_W).
  - When run reaches LOCK_LEN, the state moves to LOCKED.
  - In HUNT, error_out stays 0 and err_cnt_out does not change.
- LOCKED, valid word:
  - match: expected is loaded with data_in+1.
  - mismatch: error_out pulses, err_cnt_out increments, expected is loaded with data_in+1, run is set to 1, and the state moves to HUNT.
- valid_in=0: no state, counter or expected change.
- word_cnt_out increments on every valid word in either state.
- All counters saturate at 2^CNT_W−1; they never wrap.
- Wrap handling: expected after 0xFFFFFFFF is 0x00000000, which is an ordinary match and not an error.
- clear_in together with valid_in: the clear wins, the word is discarded and not counted, all counters go to 0, and expected goes to 0.

## Timing
- Values at reset and clear:
  - locked_out=0, error_out=0, all counters 0.
  - expected=0 and run=0.
  - State is HUNT.
- All outputs are registered. A word sampled at edge N is reflected in the outputs after edge N.
- Lock time: locked_out rises after the LOCK_LEN-th consecutive in-sequence valid word. A stream starting at the expected value locks after LOCK_LEN words.
- After a mismatch, locked_out falls in the same cycle that error_out pulses.
- Re-lock needs LOCK_LEN−1 further in-sequence words, because the mismatching word is counted as run=1.
- error_out is high for exactly one cycle per mismatch. Back-to-back mismatches produce only one pulse, because the second one arrives in HUNT.
- An asserted reset mid-stream clears everything immediately, without waiting for a clock edge.

## Configuration
- Macro: TRANSMISSION_CHECK_LOST_EN.
- Defined:
  - On a LOCKED mismatch, lost_cnt_out is increased by (data_in − expected) mod 2^DATA_W, truncated to CNT_W.
  - The accumulation saturates at 2^CNT_W−1.
  - lost_cnt_out is cleared by reset and by clear_in.
- Undefined: the lost_cnt_out port and its subtractor/accumulator are absent, and all other behaviour is identical.

## Structure
- Package transmission_pkg holds:
  - the state enum (HUNT, LOCKED);
  - default widths DATA_W_DEF=32 and CNT_W_DEF=32;
  - LOCK_LEN_DEF=4.
- One sub-module, sat_counter, is natural: a parameterised saturating accumulator with clear and increment-amount inputs.
  - It is instantiated for the word, error and (conditionally) lost counters.
- The comparator and state machine live in the top module.

## Test plan
- Reset, then words 0,1,2,3 on consecutive cycles → locked_out=1 after the 4th word; word_cnt=4; err_cnt=0; error_out never high.
- Locked at expected=10, send 13 → error_out pulses once, err_cnt=1, locked_out=0, lost_cnt=3 (macro on). Then send 14,15,16 → locked_out=1 again.
- Seed the stream at 0xFFFFFFFD and run through 0xFFFFFFFF, 0, 1 → lock is held across the wrap with err_cnt=0.
- Locked, send 50 then 7 → only one error pulse (the second mismatch arrives in HUNT) and err_cnt=1.
- Assert clear_in together with valid_in and data 5 → all counters 0, locked_out=0, word not counted. Deassert rst_n_in mid-stream → outputs go to their reset values without waiting for a clock edge.
- Force word_cnt and err_cnt to 2^CNT_W−1 using CNT_W=4 → both stay at 15 on further valid words and mismatches.
